// File: rtl/elastic_pipeline_register_pkg.sv
// Shared definitions for the elastic pipeline register: state encoding and
// default widths for the EX/MEM stage instance.
package elastic_pipeline_register_pkg;

    localparam int EXMEM_DATA_W = 32;
    localparam int EXMEM_CTRL_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SKID  = 2'd2
    } epr_state_t;

endpackage

// File: rtl/elastic_pipeline_register_entry.sv
// One pipeline entry: valid + control + payload with load, clear and reset.
// Control bits are cleared together with valid so a bubble never carries enables.
module elastic_pipeline_register_entry
    import elastic_pipeline_register_pkg::*;
#(
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int CTRL_W = EXMEM_CTRL_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge CLK) begin
        if (RST || i_clear) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_ctrl  <= i_ctrl;
        end
    end

    // Payload has no reset; it is only meaningful while r_valid is set.
    always_ff @(posedge CLK) begin
        if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_data  = r_data;

endmodule

// File: rtl/elastic_pipeline_register.sv
// Two-entry elastic (skid) pipeline register with flush. In_Ready is registered
// from state so upstream never sees a combinational path from Out_Ready.
module elastic_pipeline_register
    import elastic_pipeline_register_pkg::*;
#(
    parameter int DATA_W = EXMEM_DATA_W,
    parameter int CTRL_W = EXMEM_CTRL_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              Flush,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy
);

    epr_state_t r_state;
    epr_state_t w_state_nxt;
    logic       r_in_ready;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_main_from_skid;
    logic              w_skid_load;
    logic              w_skid_clear;
    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_main_ctrl_in;
    logic [DATA_W-1:0] w_main_data_in;

    assign w_in_fire  = In_Valid && r_in_ready;
    assign w_out_fire = w_main_valid && Out_Ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (Flush) begin
            // Any concurrent output transfer is treated as consumed; input is dropped.
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
            w_state_nxt  = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_load = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    case ({w_in_fire, w_out_fire})
                        2'b11: w_main_load = 1'b1;
                        2'b01: begin
                            w_main_clear = 1'b1;
                            w_state_nxt  = ST_EMPTY;
                        end
                        2'b10: begin
                            w_skid_load = 1'b1;
                            w_state_nxt = ST_SKID;
                        end
                        default: w_state_nxt = ST_HOLD;
                    endcase
                end
                ST_SKID: begin
                    if (w_out_fire) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                        w_state_nxt      = ST_HOLD;
                    end
                end
                default: begin
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                    w_state_nxt  = ST_EMPTY;
                end
            endcase
        end
    end

    assign w_main_ctrl_in = w_main_from_skid ? w_skid_ctrl : In_Ctrl;
    assign w_main_data_in = w_main_from_skid ? w_skid_data : In_Data;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_SKID);
        end
    end

    elastic_pipeline_register_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .CLK     (CLK),
        .RST     (RST),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_ctrl  (w_main_ctrl_in),
        .i_data  (w_main_data_in),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    elastic_pipeline_register_entry #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .CLK     (CLK),
        .RST     (RST),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_ctrl  (In_Ctrl),
        .i_data  (In_Data),
        .o_valid (w_skid_valid),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    always_comb begin
        case (r_state)
            ST_HOLD: Occupancy = 2'd1;
            ST_SKID: Occupancy = 2'd2;
            default: Occupancy = 2'd0;
        endcase
    end

    assign In_Ready  = r_in_ready;
    assign Out_Valid = w_main_valid;
    assign Out_Ctrl  = w_main_valid ? w_main_ctrl : '0;
    assign Out_Data  = w_main_data;

endmodule

// File: tb/tb_elastic_pipeline_register.sv
// Directed and randomised checks of elastic_pipeline_register against a
// queue-based reference model of a two-deep in-order buffer with flush.
module tb_elastic_pipeline_register;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          In_Valid = 1'b0;
    logic          In_Ready;
    logic [CW-1:0] In_Ctrl = '0;
    logic [DW-1:0] In_Data = '0;
    logic          Flush = 1'b0;
    logic          Out_Valid;
    logic          Out_Ready = 1'b0;
    logic [CW-1:0] Out_Ctrl;
    logic [DW-1:0] Out_Data;
    logic [1:0]    Occupancy;

    always #5 CLK = ~CLK;

    elastic_pipeline_register #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .In_Ctrl   (In_Ctrl),
        .In_Data   (In_Data),
        .Flush     (Flush),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Ctrl  (Out_Ctrl),
        .Out_Data  (Out_Data),
        .Occupancy (Occupancy)
    );

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    ent_t q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Compare every DUT output against the model's current contents.
    task automatic check_model(input string tag);
        logic [DW-1:0] exp_v, exp_c, exp_o, exp_r;
        exp_v = (q.size() > 0) ? 1 : 0;
        exp_c = (q.size() > 0) ? DW'(q[0].c) : '0;
        exp_o = DW'(q.size());
        exp_r = (q.size() < 2) ? 1 : 0;
        chk({tag, ".valid"}, DW'(Out_Valid), exp_v);
        chk({tag, ".ctrl"},  DW'(Out_Ctrl),  exp_c);
        chk({tag, ".occ"},   DW'(Occupancy), exp_o);
        chk({tag, ".ready"}, DW'(In_Ready),  exp_r);
        if (q.size() > 0) chk({tag, ".data"}, Out_Data, q[0].d);
    endtask

    // One clock: drive inputs, advance the model by the handshake rules, check.
    task automatic cyc(input string tag, input logic iv, input logic [CW-1:0] ic,
                       input logic [DW-1:0] id, input logic ordy, input logic fl,
                       input logic rst);
        bit   in_fire, out_fire;
        ent_t e;
        In_Valid  = iv;
        In_Ctrl   = ic;
        In_Data   = id;
        Out_Ready = ordy;
        Flush     = fl;
        RST       = rst;
        in_fire   = iv && (q.size() < 2);
        out_fire  = ordy && (q.size() > 0);
        @(posedge CLK);
        #1;
        if (rst || fl) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) begin
                e.c = ic;
                e.d = id;
                q.push_back(e);
            end
        end
        check_model(tag);
    endtask

    initial begin
        logic          iv, ordy, fl, rdy_before;
        logic [CW-1:0] ic;
        logic [DW-1:0] id;

        // Reset
        cyc("rst0", 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc("rst1", 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst.occ_const", DW'(Occupancy), 32'd0);
        chk("rst.ready_const", DW'(In_Ready), 32'd1);
        cyc("idle", 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset while two entries are held
        cyc("rs_a", 1'b1, 2'b11, 32'hAAAA0001, 1'b0, 1'b0, 1'b0);
        cyc("rs_b", 1'b1, 2'b11, 32'hAAAA0002, 1'b0, 1'b0, 1'b0);
        chk("rs.occ2", DW'(Occupancy), 32'd2);
        chk("rs.rdy0", DW'(In_Ready), 32'd0);
        cyc("rs_rst", 1'b1, 2'b11, 32'hAAAA0003, 1'b1, 1'b1, 1'b1);
        chk("rs.valid0", DW'(Out_Valid), 32'd0);
        chk("rs.ctrl0", DW'(Out_Ctrl), 32'd0);
        cyc("rs_idle", 1'b0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0);

        // Streaming with Out_Ready held high
        cyc("st10", 1'b1, 2'b01, 32'h10, 1'b1, 1'b0, 1'b0);
        chk("st.d10", Out_Data, 32'h10);
        cyc("st20", 1'b1, 2'b10, 32'h20, 1'b1, 1'b0, 1'b0);
        chk("st.d20", Out_Data, 32'h20);
        cyc("st30", 1'b1, 2'b11, 32'h30, 1'b1, 1'b0, 1'b0);
        chk("st.d30", Out_Data, 32'h30);
        chk("st.occ1", DW'(Occupancy), 32'd1);
        cyc("st_drain", 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);

        // Backpressure then release
        cyc("bp11", 1'b1, 2'b01, 32'h11, 1'b0, 1'b0, 1'b0);
        cyc("bp22", 1'b1, 2'b10, 32'h22, 1'b0, 1'b0, 1'b0);
        cyc("bp_hold", 1'b1, 2'b11, 32'h99, 1'b0, 1'b0, 1'b0);
        chk("bp.stable", Out_Data, 32'h11);
        chk("bp.occ2", DW'(Occupancy), 32'd2);
        cyc("bp_rel1", 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("bp.d22", Out_Data, 32'h22);
        chk("bp.rdy1", DW'(In_Ready), 32'd1);
        cyc("bp_rel2", 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("bp.empty", DW'(Out_Valid), 32'd0);

        // Flush while in SKID with a concurrent input
        cyc("fl_a", 1'b1, 2'b11, 32'h01, 1'b0, 1'b0, 1'b0);
        cyc("fl_b", 1'b1, 2'b11, 32'h02, 1'b0, 1'b0, 1'b0);
        cyc("fl_go", 1'b1, 2'b11, 32'h33, 1'b0, 1'b1, 1'b0);
        chk("fl.valid0", DW'(Out_Valid), 32'd0);
        chk("fl.ctrl0", DW'(Out_Ctrl), 32'd0);
        cyc("fl_hold1", 1'b1, 2'b11, 32'h44, 1'b1, 1'b1, 1'b0);
        cyc("fl_hold2", 1'b0, 2'b00, 32'h0, 1'b1, 1'b1, 1'b0);
        cyc("fl_after", 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("fl.no33", DW'(Out_Valid), 32'd0);

        // Randomised traffic
        for (int i = 0; i < 1000; i++) begin
            iv   = 1'($urandom_range(0, 1));
            ordy = 1'($urandom_range(0, 3) != 0 || i < 500 ? $urandom_range(0, 1) : 0);
            fl   = ($urandom_range(0, 40) == 0);
            ic   = CW'($urandom);
            id   = $urandom;
            // In_Ready must not react to Out_Ready within a cycle.
            rdy_before = In_Ready;
            Out_Ready  = ~Out_Ready;
            #1;
            chk("rnd.ready_indep", DW'(In_Ready), DW'(rdy_before));
            cyc("rnd", iv, ic, id, ordy, fl, 1'b0);
        end

        // Drain and confirm empty
        for (int i = 0; i < 3; i++) cyc("drain", 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0);
        chk("drain.empty", DW'(Occupancy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/elastic_pipeline_register.md
ELASTIC_PIPELINE_REGISTER -- requirements
Module: elastic_pipeline_register

Interface
REQ-001 Parameter DATA_W, default 32: width of the data payload (ALU result, store data, PC+4, etc. packed by the instantiating stage).
REQ-002 Parameter CTRL_W, default 2: width of safety-critical control bits (REG_W_En, MEM_W_En, ...) that are forced to 0 whenever the stage holds a bubble.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 In_Valid  input  1  upstream stage presents a valid instruction.
REQ-006 In_Ready  output  1  stage can accept a transfer this cycle.
REQ-007 In_Ctrl  input  CTRL_W  upstream control enables.
REQ-008 In_Data  input  DATA_W  upstream payload.
REQ-009 Flush  input  1  kill all held and incoming instructions (branch mispredict / hazard squash).
REQ-010 Out_Valid  output  1  stage presents a valid instruction downstream.
REQ-011 Out_Ready  input  1  downstream accepts this cycle.
REQ-012 Out_Ctrl  output  CTRL_W  downstream control enables.
REQ-013 Out_Data  output  DATA_W  downstream payload.
REQ-014 Occupancy  output  2  number of held entries (0, 1 or 2).

Function
REQ-015 Transfer in occurs on a rising edge where In_Valid && In_Ready; transfer out where Out_Valid && Out_Ready.
REQ-016 Storage: one main entry (drives outputs) plus one skid entry; each entry holds valid, ctrl, data.
REQ-017 States: EMPTY (Occupancy 0), HOLD (main valid, skid empty, Occupancy 1), SKID (both valid, Occupancy 2).
REQ-018 In_Ready is a registered function of state: 1 in EMPTY and HOLD, 0 in SKID; it never depends combinationally on Out_Ready.
REQ-019 EMPTY: transfer in -> HOLD, entry visible on outputs the next cycle (latency 1 cycle).
REQ-020 HOLD: in and out together -> HOLD with new entry; out only -> EMPTY; in only -> SKID (new entry to skid); neither -> HOLD unchanged.
REQ-021 SKID: transfer out -> HOLD, skid entry moves to main; no transfer -> SKID unchanged.
REQ-022 Order is strictly preserved; no entry is dropped or duplicated absent Flush/RST.
REQ-023 Held outputs remain stable while Out_Valid && !Out_Ready.
REQ-024 Out_Ctrl SHALL be all-zero whenever Out_Valid is 0; Out_Data is don't-care when Out_Valid is 0.
REQ-025 Flush: at the next edge both entries become invalid, state -> EMPTY, any concurrent transfer in is discarded; Flush has priority over all handshakes.
REQ-026 A concurrent transfer out during the Flush cycle is still considered consumed by downstream (it was presented); no replay.
REQ-027 Flush held for several cycles keeps the stage EMPTY; In_Ready remains 1 throughout.

Reset
REQ-028 On RST=1 at a rising edge: state EMPTY, both valid bits 0, both ctrl fields 0, Occupancy 0, Out_Valid 0, Out_Ctrl 0, In_Ready 1 the following cycle.
REQ-029 Data fields are not reset; RST has priority over Flush and all handshakes, including mid-SKID.

Structure
REQ-030 State encoding typedef (EMPTY/HOLD/SKID) lives in the shared definitions package; DATA_W/CTRL_W defaults reference package constants for the EX/MEM instance.
REQ-031 One sub-module is natural: pipe_entry (valid+ctrl+data register with load, clear, synchronous reset), instantiated twice; existing fixed-width stage registers are replaced by instances of this block.

Verification
REQ-032 RST mid-SKID (two entries 0xAAAA0001, 0xAAAA0002, ctrl 2'b11) -> next cycle Out_Valid 0, Out_Ctrl 2'b00, Occupancy 0, In_Ready 1.
REQ-033 Streaming, Out_Ready=1, inputs 0x10,0x20,0x30 on consecutive cycles -> outputs 0x10,0x20,0x30 one cycle later each, Occupancy stays 1.
REQ-034 Backpressure: Out_Ready=0, push 0x11 then 0x22 -> Occupancy 2, In_Ready 0, Out_Data 0x11 stable; raise Out_Ready -> 0x11 then 0x22 delivered, In_Ready returns to 1.
REQ-035 Flush in SKID with simultaneous In_Valid (0x33) -> next cycle Out_Valid 0, Out_Ctrl 0, Occupancy 0; 0x33 never appears.
REQ-036 Randomised valid/ready with scoreboard, 1000 cycles -> output sequence equals input sequence, Out_Ctrl 0 whenever Out_Valid 0, In_Ready never combinationally tied to Out_Ready.
